la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
Parametrised on-chip logic-analyzer capture engine. It is the successor to the fixed 21-bit, single-level-trigger analyzer instance on clk_ext8m. It samples a DATA_W-bit probe bus into a circular buffer with a runtime-programmable pre-trigger depth, mask/value trigger, optional edge qualifier, Nth-match trigger counting and sample decimation. Captured samples are read back over a simple synchronous read port. The port is driven by the debug register bridge, not by JTAG.

Parameters:
DATA_W, 21, probe bus width (1..256)
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples
DIV_W, 16, decimation counter width
CNT_W, 8, trigger match counter width

Ports:
clk_i  in  1  capture/sample clock
rst_n_i  in  1  asynchronous active-low reset
data_i  in  DATA_W  probe bus
arm_i  in  1  pulse: start capture
abort_i  in  1  pulse: return to IDLE
pre_cnt_i  in  ADDR_W  pre-trigger samples, valid 0..DEPTH-1
div_i  in  DIV_W  store 1 sample per div_i+1 clocks
trig_mask_i  in  DATA_W  1 = bit participates in compare
trig_val_i  in  DATA_W  compare value
trig_edge_en_i  in  1  additionally require an edge on trig_sel_i
trig_sel_i  in  8  edge bit index (values >= DATA_W: qualifier is always false)
trig_pol_i  in  1  1 = rising, 0 = falling
trig_num_i  in  CNT_W  fire on Nth match (0 treated as 1)
rd_addr_i  in  ADDR_W  read index, 0 = oldest sample
rd_data_o  out  DATA_W  sample, 1-cycle latency
state_o  out  3  IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4
triggered_o  out  1  trigger seen in current capture
done_o  out  1  capture complete
trig_pos_o  out  ADDR_W  index of trigger sample in readout order (= pre_cnt latched)

Behaviour:
- Clock and reset: one clock, clk_i. Asynchronous active-low reset rst_n_i.
- Reset values: state IDLE; all pointers and counters 0; triggered_o=0, done_o=0, trig_pos_o=0, rd_data_o=0. Memory contents are undefined.
- Sample strobe: a decimation counter runs while state is PRE/ARMED/POST. The strobe asserts when the counter equals div_i, then the counter reloads to 0. div_i=0 means every cycle. Trigger evaluation and buffer writes happen only on strobe cycles.
- Match logic: match = (((data_i ^ trig_val_i) & trig_mask_i) == 0) AND (!trig_edge_en_i OR edge).
  - edge compares the selected bit with its value on the previous strobe sample.
  - The previous-sample register updates on every strobe, including in PRE.
  - An all-zero mask with edge disabled matches every strobe.
- IDLE: arm_i latches pre_cnt_i, trig_num_i, div_i. Clears wr_ptr, the sample count, the match count, triggered_o and done_o. Next state PRE, or ARMED if pre_cnt=0.
- PRE: on each strobe, write data_i at wr_ptr and increment wr_ptr mod DEPTH. When pre_cnt samples are stored, go to ARMED. Matches in PRE are ignored.
- ARMED: on each strobe, write the sample (ring wraps, oldest overwritten).
  - On a match, increment the match count. When it reaches trig_num, the current sample is the trigger sample.
  - On trigger: record trig_ptr = wr_ptr, set triggered_o the next cycle, go to POST, and set the remaining count to DEPTH - pre_cnt - 1.
- POST: on each strobe, write and decrement the remaining count. At 0, go to DONE; done_o goes high in the same transition.
  - If pre_cnt=DEPTH-1, the remaining count starts at 0 and the next cycle enters DONE with no further writes.
- DONE: writes stop. done_o and triggered_o hold. arm_i re-arms exactly as from IDLE.
- abort_i from any state: go to IDLE next cycle, clear done_o and triggered_o. Memory is not cleared.
- Priority: abort_i has priority over arm_i. arm_i in PRE/ARMED/POST is ignored.
- Readout:
  - rd_data_o = mem[(trig_ptr - pre_cnt + rd_addr_i) mod DEPTH], registered with 1-cycle latency.
  - The result is valid only in DONE; other states return don't-care.
  - trig_pos_o = pre_cnt. All address arithmetic is ADDR_W-bit, wrapping.
- Memory: simple dual-port, inferrable as block RAM, write-first irrelevant (rd and wr never target the same slot in DONE).
- Config change: changing inputs mid-capture affects only live-compared fields (mask, val, edge, sel, pol). Latched fields take effect at the next arm.

Test Plan:
- Basic capture: DATA_W=21, ADDR_W=4 (DEPTH=16), data_i=counter 0,1,2..., pre_cnt=4, mask=all-ones, val=100, div=0, arm at count 90. Required: done_o after 11 more samples; readout idx0..15 = 96..111; trig_pos_o=4; idx4=100.
- Nth match with edge: trig_num=3, edge on bit0 rising, mask=0. Required: trigger on the 3rd rising edge of bit0; the readout at trig_pos_o shows bit0=1 and idx trig_pos-1 shows bit0=0.
- Decimation: div=3, counter input, pre_cnt=2, trigger val=40. Required: stored samples spaced by 4 (32,36,40,44,...); idx2=40.
- Boundaries, pre_cnt end: pre_cnt=0 with trigger on the first strobe gives idx0 = trigger sample. pre_cnt=15 gives DONE on the cycle after the trigger and idx15 = trigger sample.
- Boundaries, wrap: trigger after wr_ptr has wrapped 3 times. Required: readout remains contiguous.
- Abort mid-POST then re-arm. Required: state 3->0, done_o=0, triggered_o=0. A fresh capture completes correctly, and arm_i pulses during ARMED are ignored (state stays 2).
- Async reset during POST: assert rst_n_i low between clock edges. Required: state_o=0 and done_o=0 immediately, without waiting for an edge; after release the block stays IDLE until arm_i.

Source files
------------

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyzer capture engine. Samples a probe bus into
// a ring buffer with pre-trigger depth, mask/value/edge Nth-match trigger
// and decimation; captured window is read back oldest-first.
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   data_i                probe bus
//   arm_i, abort_i        start capture / return to IDLE
//   pre_cnt_i, div_i      pre-trigger depth, decimation (latched at arm)
//   trig_mask_i/val_i     live compare mask and value
//   trig_edge_en_i/sel_i/pol_i  live edge qualifier
//   trig_num_i            Nth match fires (latched at arm, 0 = 1)
//   rd_addr_i, rd_data_o  readout, 1-cycle latency, 0 = oldest
//   state_o, triggered_o, done_o, trig_pos_o  status
module la_capture_core #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pre_cnt_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic              trig_edge_en_i,
  input  logic [7:0]        trig_sel_i,
  input  logic              trig_pol_i,
  input  logic [CNT_W-1:0]  trig_num_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_pos_o
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_smp_cnt;
  logic [ADDR_W-1:0] r_trig_ptr;
  logic [ADDR_W-1:0] r_remain;
  logic [CNT_W-1:0]  r_trig_num;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_triggered;
  logic              r_done;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_active;
  logic              w_strobe;
  logic              w_cmp_ok;
  logic              w_sel_ok;
  logic [255:0]      w_cur_pad;
  logic [255:0]      w_prv_pad;
  logic              w_cur_bit;
  logic              w_prv_bit;
  logic              w_edge;
  logic              w_match;
  logic [CNT_W:0]    w_match_inc;
  logic [CNT_W:0]    w_num_eff;
  logic              w_nth;
  logic              w_pre_last;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_do_arm;
  logic              w_wr_en;
  logic              w_fire;

  assign w_active = (r_state == S_PRE)
                 || (r_state == S_ARMED)
                 || (r_state == S_POST);

  assign w_strobe = w_active && (r_div_cnt == r_div);

  assign w_cmp_ok =
    ((data_i ^ trig_val_i) & trig_mask_i) == '0;

  // Out-of-range select reads as constant 0 on both
  // samples, so no edge can ever be seen.
  assign w_sel_ok  = int'(trig_sel_i) < DATA_W;
  assign w_cur_pad = 256'(data_i);
  assign w_prv_pad = 256'(r_prev);
  assign w_cur_bit = w_sel_ok & w_cur_pad[trig_sel_i];
  assign w_prv_bit = w_sel_ok & w_prv_pad[trig_sel_i];

  assign w_edge = trig_pol_i ? (w_cur_bit & ~w_prv_bit)
                             : (~w_cur_bit & w_prv_bit);

  assign w_match = w_cmp_ok & (~trig_edge_en_i | w_edge);

  assign w_match_inc = {1'b0, r_match_cnt} + (CNT_W+1)'(1);
  assign w_num_eff   = (r_trig_num == '0) ? (CNT_W+1)'(1)
                                          : {1'b0, r_trig_num};
  assign w_nth       = (w_match_inc == w_num_eff);

  assign w_pre_last = ((r_smp_cnt + ADDR_W'(1)) == r_pre_cnt);

  assign w_rd_ptr = r_trig_ptr - r_pre_cnt + rd_addr_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_arm    = 1'b0;
    w_wr_en     = 1'b0;
    w_fire      = 1'b0;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            w_do_arm    = 1'b1;
            w_state_nxt = (pre_cnt_i == '0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          if (w_strobe) begin
            w_wr_en = 1'b1;
            if (w_pre_last) w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_strobe) begin
            w_wr_en = 1'b1;
            if (w_match && w_nth) begin
              w_fire      = 1'b1;
              w_state_nxt = S_POST;
            end
          end
        end
        S_POST: begin
          // r_remain counts writes still owed; the last
          // one moves straight to DONE.
          if (r_remain == '0) begin
            w_state_nxt = S_DONE;
          end else if (w_strobe) begin
            w_wr_en = 1'b1;
            if (r_remain == ADDR_W'(1)) w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_smp_cnt   <= '0;
      r_trig_ptr  <= '0;
      r_remain    <= '0;
      r_trig_num  <= '0;
      r_match_cnt <= '0;
      r_prev      <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_do_arm) begin
        r_pre_cnt   <= pre_cnt_i;
        r_trig_num  <= trig_num_i;
        r_div       <= div_i;
        r_div_cnt   <= '0;
        r_wr_ptr    <= '0;
        r_smp_cnt   <= '0;
        r_match_cnt <= '0;
      end else begin
        if (w_active) begin
          r_div_cnt <= w_strobe ? '0 : r_div_cnt + DIV_W'(1);
        end
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
        if (w_wr_en && r_state == S_PRE) begin
          r_smp_cnt <= r_smp_cnt + ADDR_W'(1);
        end
        if (w_wr_en && r_state == S_ARMED && w_match) begin
          r_match_cnt <= w_match_inc[CNT_W-1:0];
        end
        if (w_fire) begin
          r_trig_ptr <= r_wr_ptr;
          // DEPTH-1-pre_cnt post-trigger writes remain
          r_remain   <= ~r_pre_cnt;
        end else if (w_wr_en && r_state == S_POST) begin
          r_remain <= r_remain - ADDR_W'(1);
        end
      end
      if (w_strobe) begin
        r_prev <= data_i;
      end
      if (abort_i || w_do_arm) begin
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        if (w_fire) r_triggered <= 1'b1;
        if (r_state == S_POST && w_state_nxt == S_DONE) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[w_rd_ptr];
    end
  end

  assign rd_data_o   = r_rd_data;
  assign state_o     = r_state;
  assign triggered_o = r_triggered;
  assign done_o      = r_done;
  assign trig_pos_o  = r_pre_cnt;

endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed bench for la_capture_core with a
// sequence-level model of the captured window and status timing.
module tb_la_capture_core;

  localparam int DW  = 21;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam logic [DW-1:0] MALL = 21'h1FFFFF;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          arm_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] pre_cnt_i = '0;
  logic [15:0]   div_i = '0;
  logic [DW-1:0] trig_mask_i = '0;
  logic [DW-1:0] trig_val_i = '0;
  logic          trig_edge_en_i = 1'b0;
  logic [7:0]    trig_sel_i = '0;
  logic          trig_pol_i = 1'b0;
  logic [7:0]    trig_num_i = '0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [DW-1:0] rd_data_o;
  logic [2:0]    state_o;
  logic          triggered_o;
  logic          done_o;
  logic [AW-1:0] trig_pos_o;

  la_capture_core #(
    .DATA_W(DW), .ADDR_W(AW), .DIV_W(16), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i),
    .arm_i(arm_i), .abort_i(abort_i),
    .pre_cnt_i(pre_cnt_i), .div_i(div_i),
    .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i),
    .trig_edge_en_i(trig_edge_en_i), .trig_sel_i(trig_sel_i),
    .trig_pol_i(trig_pol_i), .trig_num_i(trig_num_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .state_o(state_o), .triggered_o(triggered_o),
    .done_o(done_o), .trig_pos_o(trig_pos_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int doff   = 0;
  int trig_cyc = 0;
  int done_cyc = 0;
  bit mon_on = 1'b0;
  bit rd_chk = 1'b0;
  int rd_idx = 0;
  logic [DW-1:0] rd_exp;
  logic [DW-1:0] expbuf [DEP];
  logic [DW-1:0] rb [DEP];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  // Probe stimulus: a free-running counter offset per test.
  function automatic logic [DW-1:0] data_at(input int c);
    return DW'(c + doff);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    data_i = data_at(cyc);
  endtask

  // Sample k of a capture armed in cycle a is taken in cycle
  // a+1+div+k*(div+1). The trigger is the Nth qualifying sample
  // with k >= pre; the window is samples t-pre .. t-pre+DEP-1.
  task automatic model(input int a, input int pre, input int dv,
                       input logic [DW-1:0] mask,
                       input logic [DW-1:0] val, input logic eden,
                       input int sel, input logic pol, input int num);
    int nreq;
    int m;
    int t;
    int sp;
    int c0;
    int r;
    logic [DW-1:0] s;
    logic [DW-1:0] p;
    bit hit;
    nreq = (num == 0) ? 1 : num;
    m  = 0;
    t  = -1;
    sp = dv + 1;
    c0 = a + 1 + dv;
    for (int k = 0; k < 4000 && t < 0; k++) begin
      s = data_at(c0 + k * sp);
      if (k >= pre) begin
        hit = (((s ^ val) & mask) == '0);
        if (eden) begin
          if (k == 0 || sel >= DW) hit = 1'b0;
          else begin
            p = data_at(c0 + (k - 1) * sp);
            hit = hit && (pol ? (s[sel] && !p[sel])
                              : (!s[sel] && p[sel]));
          end
        end
        if (hit) m++;
        if (m == nreq) t = k;
      end
    end
    if (t < 0) begin
      n_tot++;
      $display("FAIL model_trigger: none found");
      t = pre;
    end
    trig_cyc = c0 + t * sp + 1;
    r = DEP - 1 - pre;
    done_cyc = (r == 0) ? c0 + t * sp + 2
                        : c0 + (t + r) * sp + 1;
    for (int i = 0; i < DEP; i++)
      expbuf[i] = data_at(c0 + (t - pre + i) * sp);
  endtask

  task automatic setcfg(input int pre, input int dv,
                        input logic [DW-1:0] mask,
                        input logic [DW-1:0] val, input logic eden,
                        input int sel, input logic pol, input int num);
    pre_cnt_i      = AW'(pre);
    div_i          = 16'(dv);
    trig_mask_i    = mask;
    trig_val_i     = val;
    trig_edge_en_i = eden;
    trig_sel_i     = 8'(sel);
    trig_pol_i     = pol;
    trig_num_i     = 8'(num);
  endtask

  task automatic cap(input string nm, input int av, input int pre,
                     input int dv, input logic [DW-1:0] mask,
                     input logic [DW-1:0] val, input logic eden,
                     input int sel, input logic pol, input int num,
                     input int xarm);
    int a;
    mon_on = 1'b0;
    setcfg(pre, dv, mask, val, eden, sel, pol, num);
    doff = av - (cyc + 1);
    step();
    arm_i = 1'b1;
    a = cyc;
    model(a, pre, dv, mask, val, eden, sel, pol, num);
    while (cyc <= done_cyc) begin
      step();
      mon_on = 1'b1;
      arm_i = (xarm >= 0 && cyc == a + xarm);
      if (xarm >= 0 && cyc == a + xarm + 1)
        chk({nm, "_arm_ignored"}, 32'(state_o), 32'd2);
    end
    chk({nm, "_state_done"}, 32'(state_o), 32'd4);
    chk({nm, "_trig_pos"}, 32'(trig_pos_o), 32'(pre));
    rd_addr_i = '0;
    for (int i = 0; i < DEP; i++) begin
      step();
      rd_exp = expbuf[i];
      rd_idx = i;
      rd_chk = 1'b1;
      rd_addr_i = AW'(i + 1);
    end
    @(negedge clk_i);
    #1;
    rd_chk = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (mon_on) begin
      chk("triggered", 32'(triggered_o), 32'(cyc >= trig_cyc));
      chk("done", 32'(done_o), 32'(cyc >= done_cyc));
    end
    if (rd_chk) begin
      chk("rd_data", 32'(rd_data_o), 32'(rd_exp));
      rb[rd_idx] = rd_data_o;
    end
  end

  task automatic start_to_post(input int av);
    int a;
    mon_on = 1'b0;
    setcfg(4, 0, MALL, DW'(av + 10), 1'b0, 0, 1'b1, 1);
    doff = av - (cyc + 1);
    step();
    arm_i = 1'b1;
    a = cyc;
    step();
    arm_i = 1'b0;
    while (cyc < a + 14) step();
  endtask

  initial begin
    #1 rst_n_i = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_trig", 32'(triggered_o), 32'd0);
    chk("rst_trig_pos", 32'(trig_pos_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    step();
    step();
    rst_n_i = 1'b1;
    step();
    chk("idle_after_rst", 32'(state_o), 32'd0);

    cap("basic", 90, 4, 0, MALL, 21'd100, 1'b0, 0, 1'b1, 1, -1);
    chk("basic_idx0", 32'(rb[0]), 32'd96);
    chk("basic_idx4", 32'(rb[4]), 32'd100);
    chk("basic_idx15", 32'(rb[15]), 32'd111);

    cap("edge", 200, 4, 0, '0, '0, 1'b1, 0, 1'b1, 3, -1);
    chk("edge_idx4", 32'(rb[4]), 32'd209);
    chk("edge_idx4_b0", 32'(rb[4][0]), 32'd1);
    chk("edge_idx3_b0", 32'(rb[3][0]), 32'd0);

    start_to_post(700);
    chk("abort_pre_state", 32'(state_o), 32'd3);
    chk("abort_pre_trig", 32'(triggered_o), 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_trig", 32'(triggered_o), 32'd0);
    cap("rearm", 800, 4, 0, MALL, 21'd840, 1'b0, 0, 1'b1, 1, 20);
    chk("rearm_idx4", 32'(rb[4]), 32'd840);

    start_to_post(900);
    chk("areset_pre_state", 32'(state_o), 32'd3);
    #1 rst_n_i = 1'b0;
    #1;
    chk("areset_state", 32'(state_o), 32'd0);
    chk("areset_done", 32'(done_o), 32'd0);
    chk("areset_trig", 32'(triggered_o), 32'd0);
    step();
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("areset_idle", 32'(state_o), 32'd0);
    end

    cap("decim", 0, 2, 3, MALL, 21'd40, 1'b0, 0, 1'b1, 1, -1);
    chk("decim_idx0", 32'(rb[0]), 32'd32);
    chk("decim_idx1", 32'(rb[1]), 32'd36);
    chk("decim_idx2", 32'(rb[2]), 32'd40);

    cap("pre0", 300, 0, 0, MALL, 21'd301, 1'b0, 0, 1'b1, 0, -1);
    chk("pre0_idx0", 32'(rb[0]), 32'd301);
    chk("pre0_idx15", 32'(rb[15]), 32'd316);

    cap("pre15", 400, 15, 0, MALL, 21'd416, 1'b0, 0, 1'b1, 1, -1);
    chk("pre15_idx0", 32'(rb[0]), 32'd401);
    chk("pre15_idx15", 32'(rb[15]), 32'd416);

    cap("wrap", 500, 4, 0, MALL, 21'd560, 1'b0, 0, 1'b1, 1, -1);
    chk("wrap_idx0", 32'(rb[0]), 32'd556);
    chk("wrap_idx15", 32'(rb[15]), 32'd571);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, cyc %0d", cyc);
    $fatal(1);
  end

endmodule
